// File: rtl/clock_pkg.sv
// Shared definitions for the clock's time-of-day and countdown timer blocks.
// Contents: timer state enum, seconds-per-unit constants and the default
// largest loadable seconds value (one day minus one second).
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } timer_state_e;

  localparam int SECONDS_PER_DAY     = 86400;
  localparam int SECONDS_PER_HOUR    = 3600;
  localparam int SECONDS_PER_MIN     = 60;
  localparam int MAX_SECONDS_DEFAULT = SECONDS_PER_DAY - 1;

endpackage

// File: rtl/count_down_timer_if.sv
// Control/status bundle for count_down_timer.
//   master : drives tick/load/loadValue/start/pause, observes status
//   slave  : the timer itself
// Status: count (raw seconds), hours/minutes/seconds breakdown,
// running/expired state decodes and the one-cycle alarm pulse.
interface count_down_timer_if #(
  parameter int WIDTH = 32
);
  logic             tick;
  logic             load;
  logic [WIDTH-1:0] loadValue;
  logic             start;
  logic             pause;
  logic [WIDTH-1:0] count;
  logic [4:0]       hours;
  logic [5:0]       minutes;
  logic [5:0]       seconds;
  logic             running;
  logic             expired;
  logic             alarm;

  modport master (
    output tick, load, loadValue, start, pause,
    input  count, hours, minutes, seconds, running, expired, alarm
  );

  modport slave (
    input  tick, load, loadValue, start, pause,
    output count, hours, minutes, seconds, running, expired, alarm
  );
endinterface

// File: rtl/sec_to_hms.sv
// Combinational seconds -> HH:MM:SS breakdown, shared with the
// time-of-day display path.
// Ports:
//   total_sec : raw seconds (WIDTH bits)
//   hours     : total_sec / 3600 (5 bits, valid for values below one day)
//   minutes   : (total_sec % 3600) / 60
//   seconds   : total_sec % 60
module sec_to_hms
  import clock_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] total_sec,
  output logic [4:0]       hours,
  output logic [5:0]       minutes,
  output logic [5:0]       seconds
);

  localparam logic [WIDTH-1:0] HOUR_W = WIDTH'(SECONDS_PER_HOUR);
  localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(SECONDS_PER_MIN);

  logic [WIDTH-1:0] rem_hour;

  always_comb begin
    rem_hour = total_sec % HOUR_W;
    // Callers keep total_sec under one day, so hours fits in 5 bits.
    hours    = 5'(total_sec / HOUR_W);
    minutes  = 6'(rem_hour / MIN_W);
    seconds  = 6'(rem_hour % MIN_W);
  end

endmodule

// File: rtl/count_down_timer.sv
// Countdown timer for the clock's timer/alarm function. Loaded with a
// seconds value, decremented once per 1 Hz tick while running, pulses
// alarm for one cycle when the count reaches zero.
// Ports:
//   CLK : system clock, all state changes on posedge
//   RST : synchronous active-high reset
//   tmr : count_down_timer_if.slave (controls in, count/HMS/flags out)
// Optional build macro COUNT_DOWN_AUTO_RELOAD_EN: on the expiring tick the
// count is reloaded from the last loaded value and counting continues.
//
// state   | meaning
// --------+----------------------------------------------------
// IDLE    | loaded or reset, waiting for start
// RUNNING | decrementing on each tick
// PAUSED  | count held, start resumes
// EXPIRED | reached zero; left only by load or reset
module count_down_timer
  import clock_pkg::*;
#(
  parameter int MAX_SECONDS = MAX_SECONDS_DEFAULT,
  parameter int WIDTH       = 32
) (
  input logic               CLK,
  input logic               RST,
  count_down_timer_if.slave tmr
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_SECONDS);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_W = '0;

  timer_state_e     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             alarm_q, alarm_d;
  logic             running_q, running_d;
  logic             expired_q, expired_d;
  logic [WIDTH-1:0] load_clamped;
`ifdef COUNT_DOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  assign load_clamped = (tmr.loadValue > MAX_W) ? MAX_W : tmr.loadValue;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      count_q   <= '0;
      alarm_q   <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
`ifdef COUNT_DOWN_AUTO_RELOAD_EN
      reload_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      alarm_q   <= alarm_d;
      running_q <= running_d;
      expired_q <= expired_d;
`ifdef COUNT_DOWN_AUTO_RELOAD_EN
      reload_q  <= reload_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    alarm_d = 1'b0;
`ifdef COUNT_DOWN_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif

    if (tmr.load) begin
      count_d = load_clamped;
      state_d = IDLE;
`ifdef COUNT_DOWN_AUTO_RELOAD_EN
      reload_d = load_clamped;
`endif
    end else if (tmr.pause) begin
      // pause blocks start/tick even where it has no effect on state
      if (state_q == RUNNING) state_d = PAUSED;
    end else if (tmr.start && (state_q == IDLE || state_q == PAUSED)) begin
      // entering RUNNING swallows any coincident tick
      if (count_q != ZERO_W) state_d = RUNNING;
    end else if (tmr.tick && state_q == RUNNING) begin
      if (count_q == ONE_W) begin
        alarm_d = 1'b1;
`ifdef COUNT_DOWN_AUTO_RELOAD_EN
        count_d = reload_q;
`else
        count_d = ZERO_W;
        state_d = EXPIRED;
`endif
      end else if (count_q != ZERO_W) begin
        count_d = count_q - ONE_W;
      end
    end

    running_d = (state_d == RUNNING);
    expired_d = (state_d == EXPIRED);
  end

  assign tmr.count   = count_q;
  assign tmr.alarm   = alarm_q;
  assign tmr.running = running_q;
  assign tmr.expired = expired_q;

  sec_to_hms #(.WIDTH(WIDTH)) u_hms (
    .total_sec (count_q),
    .hours     (tmr.hours),
    .minutes   (tmr.minutes),
    .seconds   (tmr.seconds)
  );

endmodule

// File: tb/tb_count_down_timer.sv
// Directed bench for count_down_timer: reset, countdown/expiry, clamp and
// HMS breakdown, pause/resume, input priority collisions and, when built
// with COUNT_DOWN_AUTO_RELOAD_EN, the auto-reload behaviour.
module tb_count_down_timer;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  count_down_timer_if #(.WIDTH(32)) ifc ();

  count_down_timer #(.MAX_SECONDS(86399), .WIDTH(32)) dut (
    .CLK (clk),
    .RST (rst),
    .tmr (ifc.slave)
  );

  always #5 clk = ~clk;

  // One clock with the given inputs held, then inputs cleared; outputs are
  // stable when this returns (1 time unit after the edge).
  task automatic drive(input logic t, input logic ld, input logic [31:0] lv,
                       input logic st, input logic pa);
    ifc.tick      = t;
    ifc.load      = ld;
    ifc.loadValue = lv;
    ifc.start     = st;
    ifc.pause     = pa;
    @(posedge clk);
    #1;
    ifc.tick  = 1'b0;
    ifc.load  = 1'b0;
    ifc.start = 1'b0;
    ifc.pause = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.tick = 1'b0; ifc.load = 1'b0; ifc.loadValue = '0;
    ifc.start = 1'b0; ifc.pause = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (ifc.count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", ifc.count); end
    total++; if (ifc.running !== 1'b0 || ifc.expired !== 1'b0 || ifc.alarm !== 1'b0) begin
      bad++; $display("FAIL reset_flags got run=%b exp=%b alm=%b want 0/0/0", ifc.running, ifc.expired, ifc.alarm); end
    rst = 1'b0;
  endtask

  task automatic test_rst_mid_run();
    drive(0, 1, 32'd10, 0, 0);
    drive(0, 0, 0, 1, 0);
    repeat (3) drive(1, 0, 0, 0, 0);
    total++; if (ifc.count !== 32'd7) begin bad++; $display("FAIL rst_mid_pre got=%0d want=7", ifc.count); end
    rst = 1'b1;
    drive(1, 0, 0, 0, 0);
    rst = 1'b0;
    total++; if (ifc.count !== 32'd0 || ifc.running !== 1'b0 || ifc.alarm !== 1'b0) begin
      bad++; $display("FAIL rst_mid got cnt=%0d run=%b alm=%b want 0/0/0", ifc.count, ifc.running, ifc.alarm); end
    drive(0, 0, 0, 1, 0);
    total++; if (ifc.running !== 1'b0) begin bad++; $display("FAIL rst_mid_start0 got run=%b want=0", ifc.running); end
  endtask

  task automatic test_basic();
    drive(0, 1, 32'd3, 0, 0);
    total++; if (ifc.count !== 32'd3 || ifc.running !== 1'b0) begin
      bad++; $display("FAIL basic_load got cnt=%0d run=%b want 3/0", ifc.count, ifc.running); end
    drive(0, 0, 0, 1, 0);
    total++; if (ifc.running !== 1'b1 || ifc.count !== 32'd3) begin
      bad++; $display("FAIL basic_start got cnt=%0d run=%b want 3/1", ifc.count, ifc.running); end
    drive(1, 0, 0, 0, 0);
    total++; if (ifc.count !== 32'd2 || ifc.alarm !== 1'b0) begin
      bad++; $display("FAIL basic_t1 got cnt=%0d alm=%b want 2/0", ifc.count, ifc.alarm); end
    drive(1, 0, 0, 0, 0);
    total++; if (ifc.count !== 32'd1 || ifc.alarm !== 1'b0) begin
      bad++; $display("FAIL basic_t2 got cnt=%0d alm=%b want 1/0", ifc.count, ifc.alarm); end
    drive(1, 0, 0, 0, 0);
`ifdef COUNT_DOWN_AUTO_RELOAD_EN
    total++; if (ifc.count !== 32'd3 || ifc.alarm !== 1'b1 || ifc.running !== 1'b1) begin
      bad++; $display("FAIL basic_t3 got cnt=%0d alm=%b run=%b want 3/1/1", ifc.count, ifc.alarm, ifc.running); end
`else
    total++; if (ifc.count !== 32'd0 || ifc.alarm !== 1'b1 || ifc.expired !== 1'b1 || ifc.running !== 1'b0) begin
      bad++; $display("FAIL basic_t3 got cnt=%0d alm=%b exp=%b run=%b want 0/1/1/0", ifc.count, ifc.alarm, ifc.expired, ifc.running); end
    drive(0, 0, 0, 0, 0);
    total++; if (ifc.alarm !== 1'b0) begin bad++; $display("FAIL basic_alarm_width got=%b want=0", ifc.alarm); end
    drive(1, 0, 0, 0, 0);
    total++; if (ifc.count !== 32'd0 || ifc.expired !== 1'b1) begin
      bad++; $display("FAIL basic_t4 got cnt=%0d exp=%b want 0/1", ifc.count, ifc.expired); end
    drive(0, 0, 0, 1, 0);
    total++; if (ifc.expired !== 1'b1 || ifc.running !== 1'b0) begin
      bad++; $display("FAIL basic_start_exp got exp=%b run=%b want 1/0", ifc.expired, ifc.running); end
`endif
  endtask

  task automatic test_clamp();
    drive(0, 1, 32'd90000, 0, 0);
    total++; if (ifc.count !== 32'd86399 || ifc.expired !== 1'b0) begin
      bad++; $display("FAIL clamp got cnt=%0d exp=%b want 86399/0", ifc.count, ifc.expired); end
    total++; if (ifc.hours !== 5'd23 || ifc.minutes !== 6'd59 || ifc.seconds !== 6'd59) begin
      bad++; $display("FAIL clamp_hms got %0d:%0d:%0d want 23:59:59", ifc.hours, ifc.minutes, ifc.seconds); end
    drive(0, 1, 32'd3725, 0, 0);
    total++; if (ifc.hours !== 5'd1 || ifc.minutes !== 6'd2 || ifc.seconds !== 6'd5) begin
      bad++; $display("FAIL hms_3725 got %0d:%0d:%0d want 1:2:5", ifc.hours, ifc.minutes, ifc.seconds); end
    drive(0, 1, 32'd86399, 0, 0);
    total++; if (ifc.count !== 32'd86399) begin bad++; $display("FAIL clamp_edge got=%0d want=86399", ifc.count); end
    drive(0, 1, 32'hFFFF_FFFF, 0, 0);
    total++; if (ifc.count !== 32'd86399) begin bad++; $display("FAIL clamp_max got=%0d want=86399", ifc.count); end
  endtask

  task automatic test_pause();
    drive(0, 1, 32'd5, 0, 0);
    drive(0, 0, 0, 1, 0);
    repeat (2) drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    total++; if (ifc.running !== 1'b0 || ifc.count !== 32'd3) begin
      bad++; $display("FAIL pause got cnt=%0d run=%b want 3/0", ifc.count, ifc.running); end
    repeat (3) drive(1, 0, 0, 0, 0);
    total++; if (ifc.count !== 32'd3) begin bad++; $display("FAIL pause_hold got=%0d want=3", ifc.count); end
    drive(0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0);
    total++; if (ifc.count !== 32'd2 || ifc.running !== 1'b1) begin
      bad++; $display("FAIL resume got cnt=%0d run=%b want 2/1", ifc.count, ifc.running); end
    drive(1, 0, 0, 0, 1);
    total++; if (ifc.count !== 32'd2 || ifc.running !== 1'b0) begin
      bad++; $display("FAIL pause_tick got cnt=%0d run=%b want 2/0", ifc.count, ifc.running); end
    drive(0, 0, 0, 1, 1);
    total++; if (ifc.running !== 1'b0) begin bad++; $display("FAIL start_pause got run=%b want=0", ifc.running); end
    drive(0, 0, 0, 1, 0);
    total++; if (ifc.running !== 1'b1) begin bad++; $display("FAIL restart got run=%b want=1", ifc.running); end
  endtask

  task automatic test_priority();
    drive(0, 1, 32'd6, 0, 0);
    drive(0, 0, 0, 1, 0);
    repeat (2) drive(1, 0, 0, 0, 0);
    total++; if (ifc.count !== 32'd4) begin bad++; $display("FAIL prio_pre got=%0d want=4", ifc.count); end
    drive(1, 1, 32'd7, 0, 0);
    total++; if (ifc.count !== 32'd7 || ifc.running !== 1'b0) begin
      bad++; $display("FAIL load_tick got cnt=%0d run=%b want 7/0", ifc.count, ifc.running); end
    drive(1, 0, 0, 1, 0);
    total++; if (ifc.count !== 32'd7 || ifc.running !== 1'b1) begin
      bad++; $display("FAIL start_tick got cnt=%0d run=%b want 7/1", ifc.count, ifc.running); end
    drive(1, 0, 0, 0, 0);
    total++; if (ifc.count !== 32'd6) begin bad++; $display("FAIL first_tick got=%0d want=6", ifc.count); end
    drive(0, 1, 32'd0, 0, 0);
    drive(0, 0, 0, 1, 0);
    total++; if (ifc.running !== 1'b0 || ifc.count !== 32'd0 || ifc.alarm !== 1'b0) begin
      bad++; $display("FAIL start_zero got cnt=%0d run=%b alm=%b want 0/0/0", ifc.count, ifc.running, ifc.alarm); end
  endtask

`ifdef COUNT_DOWN_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    logic [31:0] exp_cnt [6];
    logic        exp_alm [6];
    exp_cnt = '{32'd1, 32'd2, 32'd1, 32'd2, 32'd1, 32'd2};
    exp_alm = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    drive(0, 1, 32'd2, 0, 0);
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 0, 0);
      total++; if (ifc.count !== exp_cnt[i] || ifc.alarm !== exp_alm[i] ||
                   ifc.running !== 1'b1 || ifc.expired !== 1'b0) begin
        bad++; $display("FAIL reload_t%0d got cnt=%0d alm=%b run=%b exp=%b want %0d/%b/1/0",
                        i + 1, ifc.count, ifc.alarm, ifc.running, ifc.expired, exp_cnt[i], exp_alm[i]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rst_mid_run();
    test_basic();
    test_clamp();
    test_pause();
    test_priority();
`ifdef COUNT_DOWN_AUTO_RELOAD_EN
    test_auto_reload();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/count_down_timer.md
Name: count_down_timer

Overview:
- Countdown timer: the decrementing counterpart of the seconds-of-day up-counter, for the clock's timer/alarm function.
- Loaded with a seconds value, decremented once per 1 Hz tick while running; raises a one-cycle alarm pulse on reaching zero.
- Sits beside the time-of-day counter.
- Drives the display path with raw seconds plus an HH:MM:SS breakdown.

Parameters:
- MAX_SECONDS, 86399, largest loadable value; larger loads clamp to it.
- WIDTH, 32, width of count and loadValue.

Ports:
- CLK  input  1  system clock; all state changes on posedge.
- RST  input  1  synchronous, active-high reset.
- tick  input  1  1 Hz enable, one CLK cycle wide.
- load  input  1  load loadValue; timer stops.
- loadValue  input  WIDTH  seconds to load.
- start  input  1  begin or resume counting.
- pause  input  1  suspend counting.
- count  output  WIDTH  remaining seconds, registered.
- hours  output  5  count/3600, combinational from count.
- minutes  output  6  (count%3600)/60.
- seconds  output  6  count%60.
- running  output  1  high in RUNNING.
- expired  output  1  high in EXPIRED.
- alarm  output  1  one-cycle pulse on expiry.

Behaviour:
- Reset: RST=1 at posedge sets state IDLE, count=0, reload register=0, alarm=0, running=0, expired=0. This applies from any state, including mid-count.
- States: IDLE, RUNNING, PAUSED, EXPIRED.
- running and expired are registered state decodes.
- Per-cycle priority: RST > load > pause > start > tick.
- load (any state):
  - count <= min(loadValue, MAX_SECONDS); reload register gets the same value.
  - Next state IDLE. A tick in the same cycle is dropped.
- pause:
  - RUNNING -> PAUSED; count held.
  - Ignored in any other state.
  - start+pause together in IDLE/PAUSED: pause wins, so no transition.
- start:
  - IDLE or PAUSED with count>0 -> RUNNING.
  - With count==0, start is ignored; state unchanged.
  - Ignored in RUNNING.
  - Ignored in EXPIRED (count is 0 there).
  - A tick in the same cycle as start is not counted; counting begins on the first tick after RUNNING is entered.
- tick in RUNNING:
  - count <= count-1 (unsigned WIDTH arithmetic).
  - If count==1: next state EXPIRED and alarm=1 for exactly that one cycle, coincident with count becoming 0.
  - Count never wraps below 0.
- EXPIRED:
  - count stays 0; expired=1.
  - Left only via load or RST.
- tick outside RUNNING: ignored.
- Latency: count and flags update one CLK after the qualifying input; hours/minutes/seconds track count combinationally.
- Load of 0 gives IDLE with count 0; start is then ignored.

Optional Feature:
- Macro: COUNT_DOWN_AUTO_RELOAD_EN.
- Defined: on the expiring tick, count <= reload register, state stays RUNNING, alarm still pulses for one cycle, EXPIRED is never entered. A reload value of 0 cannot occur here, because start is refused at count 0.
- Undefined: behaviour exactly as above; the reload register may be optimised away.

Decomposition:
- Shared package clock_pkg:
  - state enum (IDLE, RUNNING, PAUSED, EXPIRED);
  - SECONDS_PER_DAY=86400, SECONDS_PER_HOUR=3600, SECONDS_PER_MIN=60;
  - MAX_SECONDS default.
- Sub-module sec_to_hms: combinational WIDTH-bit seconds -> hours/minutes/seconds. It is reusable by the up-counter display path.

Test Plan:
- RST mid-run: load 10, start, 3 ticks, assert RST -> count=0, state IDLE, alarm stays 0.
- Basic countdown: load 3, start, 3 ticks -> count 2,1,0; alarm high exactly on the cycle count becomes 0; expired=1; a 4th tick leaves count 0.
- Clamp and breakdown: load 90000 -> count=86399, hours=23, minutes=59, seconds=59. Load 3725 -> 1/2/5.
- Pause/resume: load 5, start, 2 ticks, pause, 3 ticks -> count held at 3. Start, 1 tick -> 2. Start+pause in the same cycle while PAUSED -> stays PAUSED.
- Priority collisions:
  - Load 7 with tick in the same cycle while RUNNING at 4 -> count=7, IDLE.
  - Start with tick in the same cycle -> count unchanged that cycle.
  - Start at count 0 -> stays IDLE.
- COUNT_DOWN_AUTO_RELOAD_EN: load 2, start, 6 ticks -> count 1,0→2 (reloads),1,2... with one alarm every 2nd tick; running stays 1, expired stays 0.
